// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - step codes and opcode constants shared with the step decoder
package control_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0000,
    ST_DECODE = 4'b0001,
    ST_LOAD   = 4'b0010,
    ST_MOVE   = 4'b0011,
    ST_LDPC   = 4'b0100,
    ST_BRANCH = 4'b0101,
    ST_SUB0   = 4'b0110,
    ST_SUB1   = 4'b0111,
    ST_SUB2   = 4'b1000,
    ST_ADD0   = 4'b1001,
    ST_ADD1   = 4'b1010,
    ST_ADD2   = 4'b1011,
    ST_XOR0   = 4'b1100,
    ST_XOR1   = 4'b1101,
    ST_XOR2   = 4'b1110,
    ST_DONE   = 4'b1111
  } state_e;

  localparam logic [2:0] OP_LOAD   = 3'b000;
  localparam logic [2:0] OP_MOVE   = 3'b001;
  localparam logic [2:0] OP_LDPC   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_SUB    = 3'b100;
  localparam logic [2:0] OP_ADD    = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;
  localparam logic [2:0] OP_RSVD   = 3'b111;

  function automatic logic [2:0] ir_opcode(input logic [15:0] ir);
    return ir[15:13];
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - instruction step sequencer with IR, sticky illegal flag and retire counter
// Every output is a flop; busy/done are precomputed from the next state.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        run,
  input  logic        stall,
  input  logic [15:0] din,
  output logic [15:0] instr,
  output logic [3:0]  state,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [15:0] retired
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;
  logic [15:0] retired_q, retired_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            ir_d      = din;
            illegal_d = 1'b0;
            state_d   = ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (ir_opcode(ir_q))
            OP_LOAD:   state_d = ST_LOAD;
            OP_MOVE:   state_d = ST_MOVE;
            OP_LDPC:   state_d = ST_LDPC;
            OP_BRANCH: state_d = ST_BRANCH;
            OP_SUB:    state_d = ST_SUB0;
            OP_ADD:    state_d = ST_ADD0;
            OP_XOR:    state_d = ST_XOR0;
            default: begin
              state_d   = ST_DONE;
              illegal_d = 1'b1;
            end
          endcase
        end
        ST_LOAD, ST_MOVE, ST_LDPC, ST_BRANCH: state_d = ST_DONE;
        ST_SUB0: state_d = ST_SUB1;
        ST_SUB1: state_d = ST_SUB2;
        ST_ADD0: state_d = ST_ADD1;
        ST_ADD1: state_d = ST_ADD2;
        ST_XOR0: state_d = ST_XOR1;
        ST_XOR1: state_d = ST_XOR2;
        ST_SUB2, ST_ADD2, ST_XOR2: state_d = ST_DONE;
        ST_DONE: begin
          state_d   = ST_IDLE;
          retired_d = retired_q + 16'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      ir_q      <= 16'h0000;
      illegal_q <= 1'b0;
      retired_q <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign instr   = ir_q;
  assign state   = state_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [15:0] instr;
  logic [3:0]  state;
  logic        busy, done, illegal;
  logic [15:0] retired;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_retired = 16'h0000;
  logic [3:0]  exp_q[$];

  typedef struct {
    logic [15:0] din;
    int          lat;
    logic        ill;
  } vec_t;

  vec_t vecs[10];

  control_sequencer dut (
    .clk(clk), .resetn(resetn), .run(run), .stall(stall), .din(din),
    .instr(instr), .state(state), .busy(busy), .done(done),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference step sequence, written independently of the RTL package.
  function automatic logic [3:0] model_next(input logic [3:0] s, input logic [2:0] op);
    case (s)
      4'h1: begin
        case (op)
          3'd0: return 4'h2;
          3'd1: return 4'h3;
          3'd2: return 4'h4;
          3'd3: return 4'h5;
          3'd4: return 4'h6;
          3'd5: return 4'h9;
          3'd6: return 4'hC;
          default: return 4'hF;
        endcase
      end
      4'h2, 4'h3, 4'h4, 4'h5: return 4'hF;
      4'h6: return 4'h7;
      4'h7: return 4'h8;
      4'h9: return 4'hA;
      4'hA: return 4'hB;
      4'hC: return 4'hD;
      4'hD: return 4'hE;
      4'h8, 4'hB, 4'hE: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  task automatic check_cycle(input logic [3:0] exp_s);
    chk("state", {12'h0, state}, {12'h0, exp_s});
    chk("done", {15'h0, done}, {15'h0, (exp_s == 4'hF)});
    chk("busy", {15'h0, busy}, {15'h0, (exp_s != 4'h0)});
  endtask

  task automatic run_instr(input logic [15:0] d, input int lat, input logic ill);
    logic [3:0] s;
    int cyc;
    int got_lat;
    @(negedge clk);
    din = d;
    run = 1'b1;
    s = 4'h1;
    exp_q.push_back(s);
    while (s != 4'h0) begin
      s = model_next(s, d[15:13]);
      exp_q.push_back(s);
    end
    @(negedge clk);
    run = 1'b0;
    chk("illegal_clear_on_accept", {15'h0, illegal}, 16'h0);
    cyc = 0;
    got_lat = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      cyc++;
      if (done && got_lat == 0) got_lat = cyc;
      check_cycle(exp_q.pop_front());
      if (exp_q.size() > 0) @(negedge clk);
    end
    chk("sequence_drained", exp_q.size()[15:0], 16'h0);
    exp_q.delete();
    exp_retired = exp_retired + 16'd1;
    chk("latency", got_lat[15:0], lat[15:0]);
    chk("instr", instr, d);
    chk("illegal_end", {15'h0, illegal}, {15'h0, ill});
    chk("retired", retired, exp_retired);
  endtask

  initial begin
    vecs[0] = '{16'h0400, 3, 1'b0};
    vecs[1] = '{16'h2000, 3, 1'b0};
    vecs[2] = '{16'h4000, 3, 1'b0};
    vecs[3] = '{16'h6000, 3, 1'b0};
    vecs[4] = '{16'h8480, 5, 1'b0};
    vecs[5] = '{16'hA000, 5, 1'b0};
    vecs[6] = '{16'hC000, 5, 1'b0};
    vecs[7] = '{16'hE000, 2, 1'b1};
    vecs[8] = '{16'hA000, 5, 1'b0};
    vecs[9] = '{16'h1FFF, 3, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_state", {12'h0, state}, 16'h0);
    chk("reset_instr", instr, 16'h0);
    chk("reset_busy", {15'h0, busy}, 16'h0);
    chk("reset_done", {15'h0, done}, 16'h0);
    chk("reset_illegal", {15'h0, illegal}, 16'h0);
    chk("reset_retired", retired, 16'h0);
    resetn = 1'b1;

    // Reset asserted between edges while in ADD1.
    @(negedge clk);
    din = 16'hA000;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("add_decode", {12'h0, state}, 16'h1);
    @(negedge clk);
    chk("add_add0", {12'h0, state}, 16'h9);
    @(negedge clk);
    chk("add_add1", {12'h0, state}, 16'hA);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_state", {12'h0, state}, 16'h0);
    chk("async_rst_instr", instr, 16'h0);
    chk("async_rst_retired", retired, 16'h0);
    chk("async_rst_busy", {15'h0, busy}, 16'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_retired", retired, 16'h0);

    for (int i = 0; i < 10; i++) run_instr(vecs[i].din, vecs[i].lat, vecs[i].ill);

    // run with stall in IDLE must not be accepted.
    @(negedge clk);
    din = 16'h1234;
    run = 1'b1;
    stall = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("stall_idle_state", {12'h0, state}, 16'h0);
      chk("stall_idle_instr", instr, 16'h1FFF);
    end
    run = 1'b0;
    stall = 1'b0;

    // XOR with 3 stall cycles in XOR1, then a stall in DONE extending done.
    begin
      logic [3:0] exp_s[10] = '{4'h1, 4'hC, 4'hD, 4'hD, 4'hD, 4'hD, 4'hE, 4'hF, 4'hF, 4'h0};
      logic       stl[10]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int got_lat;
      got_lat = 0;
      @(negedge clk);
      din = 16'hC000;
      run = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        run = 1'b0;
        if (done && got_lat == 0) got_lat = c + 1;
        check_cycle(exp_s[c]);
        stall = stl[c];
      end
      stall = 1'b0;
      exp_retired = exp_retired + 16'd1;
      chk("stall_latency", got_lat[15:0], 16'd8);
      chk("stall_retired", retired, exp_retired);
    end

    // Counter wrap from 0xFFFF.
    @(negedge clk);
    force dut.retired_q = 16'hFFFF;
    @(negedge clk);
    release dut.retired_q;
    @(negedge clk);
    chk("preload_retired", retired, 16'hFFFF);
    exp_retired = 16'hFFFF;
    run_instr(16'h0400, 3, 1'b0);
    chk("wrap_retired", retired, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have these ports, clock and reset first (name  direction  width  meaning):
  clk  in  1  single system clock, rising edge.
  resetn  in  1  asynchronous active-low reset.
  run  in  1  start request, sampled only in IDLE.
  stall  in  1  freeze request; holds the current state and all registers.
  din  in  16  instruction word, captured on the accepted run.
  instr  out  16  latched instruction register (IR), fed to the step decoder.
  state  out  4  current step code, fed to the step decoder.
  busy  out  1  high in every state except IDLE.
  done  out  1  high only in DONE.
  illegal  out  1  sticky flag for a reserved opcode.
  retired  out  16  count of completed instructions.
REQ-002 Clocking and reset SHALL be one clock, clk, with reset resetn asynchronous and active-low.

Function
REQ-003 Opcode SHALL be IR[15:13]; rx = IR[12:10], ry = IR[9:7]; the block SHALL NOT decode rx or ry.
REQ-004 State encoding SHALL be fixed:
  IDLE 0000, DECODE 0001, LOAD 0010, MOVE 0011, LDPC 0100, BRANCH 0101.
  SUB0-2 0110/0111/1000, ADD0-2 1001/1010/1011, XOR0-2 1100/1101/1110, DONE 1111.
REQ-005 Opcode map SHALL be 000 load, 001 move, 010 ldpc, 011 branch, 100 sub, 101 add, 110 xor, 111 reserved.
REQ-006 In IDLE with run=1 and stall=0, the block SHALL load din into IR and go to DECODE next cycle; otherwise it SHALL stay in IDLE with IR unchanged.
REQ-007 DECODE SHALL go to the opcode's first step: LOAD, MOVE, LDPC, BRANCH, SUB0, ADD0 or XOR0.
REQ-008 Single-step states (LOAD, MOVE, LDPC, BRANCH) SHALL go to DONE.
REQ-009 Three-step ops SHALL advance 0->1->2->DONE, one state per cycle.
REQ-010 Reserved opcode 111: DECODE SHALL go directly to DONE and set illegal=1.
REQ-011 illegal SHALL remain set until the next accepted run, which clears it in the same edge that loads IR.
REQ-012 DONE SHALL last exactly one cycle with done=1, then go to IDLE.
REQ-013 run SHALL be ignored in DONE, so back-to-back instructions need one IDLE cycle.
REQ-014 retired SHALL increment by 1 on the DONE->IDLE edge, including for illegal instructions, and SHALL wrap from 0xFFFF to 0x0000.
REQ-015 Latency from the accepted-run edge to done=1 SHALL be:
  3 cycles for single-step ops.
  5 cycles for sub, add and xor.
  2 cycles for the reserved opcode.
REQ-016 While stall=1, the block SHALL hold state, IR, illegal and retired.
  Outputs SHALL remain at their current values, so a stall in DONE extends done.
  Each stall cycle SHALL add one cycle to latency.
REQ-017 When run and stall are both 1 in IDLE, stall SHALL win and the run SHALL NOT be accepted.
REQ-018 An undefined state value SHALL never occur; the default transition SHALL go to IDLE.
REQ-019 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-020 On resetn=0, the block SHALL immediately set state=IDLE, instr=0, illegal=0, retired=0, done=0 and busy=0, regardless of clk.
REQ-021 Reset asserted mid-instruction SHALL abandon the instruction without incrementing retired.
REQ-022 After reset deasserts, the first accepted run SHALL behave as in REQ-006.

Structure
REQ-023 The 4-bit state codes and 3-bit opcode constants SHALL live in a shared package used by both this block and the step decoder.
REQ-024 No sub-module is required; the block SHALL be a single module containing the FSM, IR, illegal flag and retired counter.

Verification
REQ-025 Load: din=0x0400 (op 000, rx=1), run pulse.
  Required: state 0001, 0010, 1111, 0000 on successive cycles.
  Required: done high for 1 cycle; retired=1; instr=0x0400.
REQ-026 Sub: din=0x8480 (op 100), run pulse.
  Required: state 0001, 0110, 0111, 1000, 1111, 0000.
  Required: done 5 cycles after the accepted run.
REQ-027 Reserved: din=0xE000, run pulse.
  Required: state 0001, 1111, 0000; illegal=1 and held.
  Then add din=0xA000: illegal clears on acceptance; retired increments twice in total.
REQ-028 Stall: during xor (din=0xC000), hold stall=1 for 3 cycles in XOR1.
  Required: state stays 1101 for those cycles; done arrives 8 cycles after the accepted run.
  Also: run with stall=1 in IDLE is not accepted.
REQ-029 Reset: assert resetn=0 while in ADD1 between clock edges.
  Required: state=0000 and instr=0x0000 before the next edge; retired unchanged at 0.
REQ-030 Wrap: preload the count through 65535 retires (or a force to 0xFFFF), then complete one instruction.
  Required: retired=0x0000.
